// File: rtl/mbc3_cart_mapper_pkg.sv
// MBC3 cartridge mapper shared definitions.
// Region decode, RTC register codes, field limits and the RTC bundle.
package mbc3_cart_mapper_pkg;

    // CPU address [15:13] regions that the mapper decodes
    localparam logic [2:0] RGN_RAMEN = 3'd0;
    localparam logic [2:0] RGN_BANK  = 3'd1;
    localparam logic [2:0] RGN_SEL   = 3'd2;
    localparam logic [2:0] RGN_LATCH = 3'd3;
    localparam logic [2:0] RGN_RAM   = 3'd5;

    // RTC register select codes
    localparam logic [3:0] RTC_SEC    = 4'h8;
    localparam logic [3:0] RTC_MIN    = 4'h9;
    localparam logic [3:0] RTC_HR     = 4'hA;
    localparam logic [3:0] RTC_DAY_LO = 4'hB;
    localparam logic [3:0] RTC_DAY_HI = 4'hC;

    // Last in-range value of each counter field
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [8:0] DAY_MAX = 9'd511;

    typedef enum logic [1:0] {
        SRC_FF,
        SRC_ROM,
        SRC_RAM,
        SRC_RTC
    } src_t;

    typedef enum logic {
        LATCH_IDLE,
        LATCH_ARMED
    } latch_t;

    typedef struct packed {
        logic       carry;
        logic       halt;
        logic [8:0] day;
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec;
    } rtc_t;

    // CPU-visible byte of an RTC register; non-RTC selects read FF
    function automatic logic [7:0] rtc_byte(rtc_t r, logic [3:0] sel);
        logic [7:0] b;
        unique case (sel)
            RTC_SEC:    b = {2'b00, r.sec};
            RTC_MIN:    b = {2'b00, r.min};
            RTC_HR:     b = {3'b000, r.hr};
            RTC_DAY_LO: b = r.day[7:0];
            RTC_DAY_HI: b = {r.carry, r.halt, 5'b0, r.day[8]};
            default:    b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mbc3_cart_mapper_rtc.sv
// MBC3 real-time clock: prescaler, live and latched counters.
// Written fields override the tick result; the carry chain still advances.
module mbc3_cart_mapper_rtc
    import mbc3_cart_mapper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4194304
) (
    input  logic       core_clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_sel,
    input  logic [7:0] wr_data,
    input  logic       latch,
    output rtc_t       latched
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc;
    rtc_t          live;
    rtc_t          live_nxt;
    logic          tick;
    logic          c_min;
    logic          c_hr;
    logic          c_day;

    assign tick = !live.halt && (presc == PRE_LAST);

    // Next live value: ripple the tick through the fields, then apply writes
    always_comb begin
        live_nxt = live;
        c_min    = 1'b0;
        c_hr     = 1'b0;
        c_day    = 1'b0;
        if (tick) begin
            c_min        = (live.sec == SEC_MAX);
            live_nxt.sec = c_min ? 6'd0 : live.sec + 6'd1;
            if (c_min) begin
                c_hr         = (live.min == MIN_MAX);
                live_nxt.min = c_hr ? 6'd0 : live.min + 6'd1;
            end
            if (c_hr) begin
                c_day       = (live.hr == HR_MAX);
                live_nxt.hr = c_day ? 5'd0 : live.hr + 5'd1;
            end
            if (c_day) begin
                live_nxt.day = live.day + 9'd1;
                if (live.day == DAY_MAX) begin
                    live_nxt.carry = 1'b1;
                end
            end
        end
        if (wr_en) begin
            unique case (wr_sel)
                RTC_SEC:    live_nxt.sec      = wr_data[5:0];
                RTC_MIN:    live_nxt.min      = wr_data[5:0];
                RTC_HR:     live_nxt.hr       = wr_data[4:0];
                RTC_DAY_LO: live_nxt.day[7:0] = wr_data;
                RTC_DAY_HI: begin
                    live_nxt.day[8] = wr_data[0];
                    live_nxt.halt   = wr_data[6];
                    live_nxt.carry  = wr_data[7];
                end
                default: ;
            endcase
        end
    end

    // Prescaler, live counters and latch copy
    always_ff @(posedge core_clk) begin
        if (reset) begin
            presc   <= '0;
            live    <= '0;
            latched <= '0;
        end else begin
            if (wr_en && wr_sel == RTC_SEC) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else if (!live.halt) begin
                presc <= presc + 1'b1;
            end
            live <= live_nxt;
            if (latch) begin
                latched <= live;
            end
        end
    end

endmodule

// File: rtl/mbc3_cart_mapper.sv
// MBC3 mapper: register decode, ROM/RAM banking, latch FSM, read mux.
// Read data is returned one cycle after cpu_rd, aligned with ROM/RAM.
module mbc3_cart_mapper
    import mbc3_cart_mapper_pkg::*;
#(
    parameter int ROM_AW        = 21,
    parameter int RAM_AW        = 15,
    parameter int TICKS_PER_SEC = 4194304
) (
    input  logic              core_clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        cart_rdata
);

    logic        ram_en;
    logic [6:0]  rom_bank;
    logic [3:0]  ram_sel;
    latch_t      lstate;
    latch_t      lstate_nxt;
    logic        latch_stb;
    logic [2:0]  region;
    logic        in_ram;
    logic        sel_ram;
    logic        sel_rtc;
    logic        rtc_we;
    logic [20:0] rom_full;
    logic [14:0] ram_full;
    src_t        src;
    src_t        src_q;
    logic [7:0]  rtc_q;
    rtc_t        rtc_lat;

    assign region  = cpu_addr[15:13];
    assign in_ram  = (region == RGN_RAM);
    assign sel_ram = (ram_sel[3:2] == 2'b00);
    assign sel_rtc = (ram_sel >= RTC_SEC) && (ram_sel <= RTC_DAY_HI);

    assign rom_full = cpu_addr[14] ? {rom_bank, cpu_addr[13:0]}
                                   : {7'd0, cpu_addr[13:0]};
    assign ram_full = {ram_sel[1:0], cpu_addr[12:0]};
    assign rom_addr = ROM_AW'(rom_full);
    assign ram_addr = RAM_AW'(ram_full);

    assign ram_wdata = cpu_wdata;
    assign ram_we    = cpu_wr && in_ram && ram_en && sel_ram;
    assign rtc_we    = cpu_wr && in_ram && ram_en && sel_rtc;

    // Mapper control registers written through the ROM window
    always_ff @(posedge core_clk) begin
        if (reset) begin
            ram_en   <= 1'b0;
            rom_bank <= 7'd1;
            ram_sel  <= 4'd0;
        end else if (cpu_wr) begin
            unique case (region)
                RGN_RAMEN: ram_en <= (cpu_wdata[3:0] == 4'hA);
                RGN_BANK: rom_bank <= (cpu_wdata[6:0] == 7'd0)
                                      ? 7'd1 : cpu_wdata[6:0];
                RGN_SEL: ram_sel <= cpu_wdata[3:0];
                default: ;
            endcase
        end
    end

    // Latch FSM state register
    always_ff @(posedge core_clk) begin
        if (reset) begin
            lstate <= LATCH_IDLE;
        end else begin
            lstate <= lstate_nxt;
        end
    end

    // Latch FSM: a 00 then 01 write pair copies the live clock
    always_comb begin
        lstate_nxt = lstate;
        latch_stb  = 1'b0;
        if (cpu_wr && region == RGN_LATCH) begin
            unique case (lstate)
                LATCH_IDLE: begin
                    if (cpu_wdata == 8'h00) begin
                        lstate_nxt = LATCH_ARMED;
                    end
                end
                LATCH_ARMED: begin
                    lstate_nxt = LATCH_IDLE;
                    latch_stb  = (cpu_wdata == 8'h01);
                end
            endcase
        end
    end

    mbc3_cart_mapper_rtc #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_rtc (
        .core_clk(core_clk),
        .reset   (reset),
        .wr_en   (rtc_we),
        .wr_sel  (ram_sel),
        .wr_data (cpu_wdata),
        .latch   (latch_stb),
        .latched (rtc_lat)
    );

    // Read source for the current request
    always_comb begin
        src = SRC_FF;
        if (!cpu_addr[15]) begin
            src = SRC_ROM;
        end else if (in_ram && ram_en) begin
            if (sel_ram) begin
                src = SRC_RAM;
            end else if (sel_rtc) begin
                src = SRC_RTC;
            end
        end
    end

    // Register the source and the RTC byte as seen before any same-cycle write
    always_ff @(posedge core_clk) begin
        if (reset) begin
            src_q <= SRC_FF;
            rtc_q <= 8'hFF;
        end else begin
            src_q <= cpu_rd ? src : SRC_FF;
            rtc_q <= rtc_byte(rtc_lat, ram_sel);
        end
    end

    // Return mux, one cycle after the request
    always_comb begin
        unique case (src_q)
            SRC_ROM: cart_rdata = rom_rdata;
            SRC_RAM: cart_rdata = ram_rdata;
            SRC_RTC: cart_rdata = rtc_q;
            default: cart_rdata = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_mbc3_cart_mapper.sv
// Bench for mbc3_cart_mapper: directed steps then random traffic.
// Expected values come from a field-level model of the MBC3 rules.
module tb_mbc3_cart_mapper;

    localparam int TPS = 8;

    logic        core_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [20:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  cart_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:32767];
    logic [7:0] m_ram [0:32767];

    // model state
    bit m_en;
    int m_bank;
    int m_sel;
    bit m_armed;
    int sec, mn, hr, day, presc;
    bit halt, carry;
    int l_sec, l_min, l_hr, l_day;
    bit l_halt, l_carry;

    logic [7:0]  obs_rd;
    logic        obs_we;
    logic [14:0] obs_ram_addr;
    logic [20:0] obs_rom_addr;

    always #5 core_clk = ~core_clk;

    mbc3_cart_mapper #(
        .ROM_AW       (21),
        .RAM_AW       (15),
        .TICKS_PER_SEC(TPS)
    ) dut (
        .core_clk  (core_clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .cart_rdata(cart_rdata)
    );

    function automatic logic [7:0] rom_byte(int unsigned a);
        return 8'((a * 7) ^ (a >> 11) ^ (a >> 17));
    endfunction

    // cart ROM and RAM: 1-cycle synchronous read, read-before-write
    always @(posedge core_clk) begin
        rom_rdata <= rom_byte(32'(rom_addr));
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_bank = 1; m_sel = 0; m_armed = 0;
        sec = 0; mn = 0; hr = 0; day = 0; presc = 0;
        halt = 0; carry = 0;
        l_sec = 0; l_min = 0; l_hr = 0; l_day = 0;
        l_halt = 0; l_carry = 0;
    endtask

    function automatic logic [7:0] exp_read(logic [15:0] a);
        int ra;
        if (a < 16'h8000) begin
            ra = (a % 16384) + ((a >= 16'h4000) ? m_bank * 16384 : 0);
            return rom_byte(ra);
        end
        if (a >= 16'hA000 && a < 16'hC000) begin
            if (!m_en) return 8'hFF;
            if (m_sel < 4) return m_ram[m_sel * 8192 + a % 8192];
            case (m_sel)
                8:  return 8'(l_sec);
                9:  return 8'(l_min);
                10: return 8'(l_hr);
                11: return 8'(l_day % 256);
                12: return {l_carry, l_halt, 5'b0, (l_day > 255)};
                default: return 8'hFF;
            endcase
        end
        return 8'hFF;
    endfunction

    task automatic model_update(input logic [15:0] a, input logic [7:0] w,
                                input bit wr);
        int ns, nm, nh, nd, np;
        bit nc, nhalt, tick, c;
        tick = !halt && presc == TPS - 1;
        np = halt ? presc : (tick ? 0 : presc + 1);
        ns = sec; nm = mn; nh = hr; nd = day; nc = carry; nhalt = halt;
        if (tick) begin
            c = (sec == 59);
            ns = c ? 0 : (sec + 1) % 64;
            if (c) begin
                c = (mn == 59);
                nm = c ? 0 : (mn + 1) % 64;
                if (c) begin
                    c = (hr == 23);
                    nh = c ? 0 : (hr + 1) % 32;
                    if (c) begin
                        if (day == 511) begin nd = 0; nc = 1; end
                        else nd = day + 1;
                    end
                end
            end
        end
        if (wr) begin
            case (a[15:13])
                3'd0: m_en = (w % 16) == 10;
                3'd1: m_bank = ((w % 128) == 0) ? 1 : w % 128;
                3'd2: m_sel = w % 16;
                3'd3: begin
                    if (m_armed) begin
                        if (w == 1) begin
                            l_sec = sec; l_min = mn; l_hr = hr;
                            l_day = day; l_halt = halt; l_carry = carry;
                        end
                        m_armed = 0;
                    end else begin
                        m_armed = (w == 0);
                    end
                end
                3'd5: if (m_en) begin
                    if (m_sel < 4) m_ram[m_sel * 8192 + a % 8192] = w;
                    else case (m_sel)
                        8: begin ns = w % 64; np = 0; end
                        9: nm = w % 64;
                        10: nh = w % 32;
                        11: nd = (nd / 256) * 256 + w;
                        12: begin
                            nd = nd % 256 + (w % 2) * 256;
                            nhalt = w[6];
                            nc = w[7];
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        sec = ns; mn = nm; hr = nh; day = nd;
        carry = nc; halt = nhalt; presc = np;
    endtask

    // one clock: drive, check combinational outputs, clock, check read data
    task automatic step(input logic [15:0] a, input logic [7:0] w,
                        input bit wr, input bit rd);
        logic [7:0] exp;
        bit exp_we;
        bit ram_acc;
        int exp_raddr, exp_romaddr;
        cpu_addr = a; cpu_wdata = w; cpu_wr = wr; cpu_rd = rd;
        ram_acc = a[15:13] == 3'd5 && m_en && m_sel < 4;
        exp_we = wr && ram_acc;
        exp_raddr = (m_sel % 4) * 8192 + a % 8192;
        exp_romaddr = a % 16384 + ((a >= 16'h4000) ? m_bank * 16384 : 0);
        exp = (rd && !reset) ? exp_read(a) : 8'hFF;
        #4;
        obs_we = ram_we;
        obs_ram_addr = ram_addr;
        obs_rom_addr = rom_addr;
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (ram_acc && (wr || rd))
            chk("ram_addr", 32'(ram_addr), exp_raddr);
        if (rd && a < 16'h8000)
            chk("rom_addr", 32'(rom_addr), exp_romaddr);
        @(posedge core_clk);
        if (reset) model_reset();
        else model_update(a, w, wr);
        #1;
        obs_rd = cart_rdata;
        chk("cart_rdata", 32'(cart_rdata), 32'(exp));
    endtask

    task automatic wr8(input logic [15:0] a, input logic [7:0] w);
        step(a, w, 1'b1, 1'b0);
    endtask

    task automatic rd8(input logic [15:0] a);
        step(a, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'hFF80, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rtc_rd(input logic [7:0] sel);
        wr8(16'h4000, sel);
        rd8(16'hA000);
    endtask

    task automatic latch();
        wr8(16'h6000, 8'h00);
        wr8(16'h6000, 8'h01);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0] w;
        bit wr, rd;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 8'h00;
            m_ram[i] = 8'h00;
        end
        model_reset();
        @(posedge core_clk);
        #1;

        // 1: reset and first ROM read
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("reset_rdata", 32'(cart_rdata), 32'hFF);
        rd8(16'h4123);
        chk("rom_4123", 32'(obs_rom_addr), 32'h04123);

        // 2: bank 0 maps to 1, bank 7F
        wr8(16'h2000, 8'h00);
        rd8(16'h4000);
        chk("rom_bank0", 32'(obs_rom_addr), 32'h04000);
        wr8(16'h2000, 8'h7F);
        rd8(16'h4000);
        chk("rom_bank7f", 32'(obs_rom_addr), 32'h1FC000);

        // 3: RAM bank write, then RAM disabled
        wr8(16'h0000, 8'h0A);
        wr8(16'h4000, 8'h02);
        wr8(16'hA005, 8'h5A);
        chk("ram_we_on", 32'(obs_we), 32'h1);
        chk("ram_addr_4005", 32'(obs_ram_addr), 32'h4005);
        rd8(16'hA005);
        chk("ram_rd_5a", 32'(obs_rd), 32'h5A);
        wr8(16'h0000, 8'h00);
        wr8(16'hA005, 8'h33);
        chk("ram_we_off", 32'(obs_we), 32'h0);
        rd8(16'hA005);
        chk("ram_rd_off", 32'(obs_rd), 32'hFF);

        // 4: full rollover 511d 23:59:59 -> 0 with carry
        wr8(16'h0000, 8'h0A);
        wr8(16'h4000, 8'h0C); wr8(16'hA000, 8'h41);
        wr8(16'h4000, 8'h0B); wr8(16'hA000, 8'hFF);
        wr8(16'h4000, 8'h0A); wr8(16'hA000, 8'd23);
        wr8(16'h4000, 8'h09); wr8(16'hA000, 8'd59);
        wr8(16'h4000, 8'h08); wr8(16'hA000, 8'd59);
        wr8(16'h4000, 8'h0C); wr8(16'hA000, 8'h01);
        idle(8);
        latch();
        rtc_rd(8'h08); chk("wrap_sec", 32'(obs_rd), 32'h00);
        rtc_rd(8'h09); chk("wrap_min", 32'(obs_rd), 32'h00);
        rtc_rd(8'h0A); chk("wrap_hr", 32'(obs_rd), 32'h00);
        rtc_rd(8'h0B); chk("wrap_daylo", 32'(obs_rd), 32'h00);
        rtc_rd(8'h0C); chk("wrap_dayhi", 32'(obs_rd), 32'h80);

        // 5: halt freezes the clock; broken latch sequence is ignored
        wr8(16'h4000, 8'h08); wr8(16'hA000, 8'h0A);
        wr8(16'h4000, 8'h0C); wr8(16'hA000, 8'h40);
        idle(100);
        latch();
        rtc_rd(8'h0C); chk("halt_flag", 32'(obs_rd), 32'h40);
        rtc_rd(8'h08); chk("halt_sec", 32'(obs_rd), 32'h0A);
        wr8(16'hA000, 8'h14);
        wr8(16'h6000, 8'h00);
        wr8(16'h6000, 8'h05);
        wr8(16'h6000, 8'h01);
        rd8(16'hA000);
        chk("nolatch_sec", 32'(obs_rd), 32'h0A);

        // 6: seconds write on the tick cycle; minutes still carry
        wr8(16'h4000, 8'h08); wr8(16'hA000, 8'd59);
        wr8(16'h4000, 8'h09); wr8(16'hA000, 8'h05);
        wr8(16'h4000, 8'h0C); wr8(16'hA000, 8'h00);
        wr8(16'h4000, 8'h08);
        idle(6);
        wr8(16'hA000, 8'h2A);
        latch();
        rtc_rd(8'h08); chk("coinc_sec", 32'(obs_rd), 32'h2A);
        rtc_rd(8'h09); chk("coinc_min", 32'(obs_rd), 32'h06);

        // reset mid-count
        idle(3);
        reset = 1'b1;
        rd8(16'hA000);
        reset = 1'b0;
        rd8(16'hA000);
        chk("rst_ram_off", 32'(obs_rd), 32'hFF);
        rd8(16'h4000);
        chk("rst_bank", 32'(obs_rom_addr), 32'h04000);
        wr8(16'h0000, 8'h0A);
        latch();
        rtc_rd(8'h08); chk("rst_sec", 32'(obs_rd), 32'h00);
        rtc_rd(8'h0C); chk("rst_dayhi", 32'(obs_rd), 32'h00);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            w = 8'($urandom_range(0, 255));
            a = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 7))
                0: begin
                    a = {3'd0, a[12:0]};
                    if ($urandom_range(0, 2) != 0) w = 8'h0A;
                end
                1: a = {3'd1, a[12:0]};
                2: begin
                    a = {3'd2, a[12:0]};
                    w = 8'($urandom_range(0, 15));
                end
                3: begin
                    a = {3'd3, a[12:0]};
                    w = 8'($urandom_range(0, 2));
                end
                4, 5: a = {3'd5, a[12:0]};
                6: a[15] = 1'b0;
                default: ;
            endcase
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step(a, w, 1'b0, rd);
                reset = 1'b0;
            end else begin
                step(a, w, wr, rd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
